// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch core: run/pause/lap/clear control over a tick-enabled counter.
// Digit outputs show the lap snapshot while in LAP, otherwise the live count.
module stopwatch_counter #(
  parameter int unsigned MAX_MINUTES = 59
) (
  input  logic       Clk_100mhz,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Start_stop,
  input  logic       Lap,
  input  logic       Clear,
  output logic [3:0] Sec_ones,
  output logic [3:0] Sec_tens,
  output logic [3:0] Min_ones,
  output logic [3:0] Min_tens,
  output logic       Running,
  output logic       Lap_active,
  output logic       Wrap
);

  localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MINUTES % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, LAP} state_t;

  state_t     state_q, state_d;
  logic [3:0] s1_q, s10_q, m1_q, m10_q;
  logic [3:0] s1_d, s10_d, m1_d, m10_d;
  logic [3:0] snap_s1_q, snap_s10_q, snap_m1_q, snap_m10_q;
  logic [3:0] snap_s1_d, snap_s10_d, snap_m1_d, snap_m10_d;
  logic [3:0] inc_s1, inc_s10, inc_m1, inc_m10;
  logic       wrap_q, wrap_d;
  logic       count_en, at_max;

  always_ff @(posedge Clk_100mhz) begin
    if (Rst) begin
      state_q    <= IDLE;
      s1_q       <= '0;
      s10_q      <= '0;
      m1_q       <= '0;
      m10_q      <= '0;
      snap_s1_q  <= '0;
      snap_s10_q <= '0;
      snap_m1_q  <= '0;
      snap_m10_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s10_q      <= s10_d;
      m1_q       <= m1_d;
      m10_q      <= m10_d;
      snap_s1_q  <= snap_s1_d;
      snap_s10_q <= snap_s10_d;
      snap_m1_q  <= snap_m1_d;
      snap_m10_q <= snap_m10_d;
      wrap_q     <= wrap_d;
    end
  end

  // BCD ripple increment of the live count, wrapping to 00:00 after MAX_MINUTES:59
  always_comb begin
    inc_s1  = s1_q;
    inc_s10 = s10_q;
    inc_m1  = m1_q;
    inc_m10 = m10_q;
    at_max  = (m10_q == MAX_MIN_TENS) && (m1_q == MAX_MIN_ONES) &&
              (s10_q == 4'd5) && (s1_q == 4'd9);
    if (at_max) begin
      inc_s1  = '0;
      inc_s10 = '0;
      inc_m1  = '0;
      inc_m10 = '0;
    end else if (s1_q != 4'd9) begin
      inc_s1 = s1_q + 4'd1;
    end else begin
      inc_s1 = '0;
      if (s10_q != 4'd5) begin
        inc_s10 = s10_q + 4'd1;
      end else begin
        inc_s10 = '0;
        if (m1_q != 4'd9) begin
          inc_m1 = m1_q + 4'd1;
        end else begin
          inc_m1  = '0;
          inc_m10 = m10_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    count_en   = Tick && (state_q == RUN || state_q == LAP);
    s1_d       = count_en ? inc_s1  : s1_q;
    s10_d      = count_en ? inc_s10 : s10_q;
    m1_d       = count_en ? inc_m1  : m1_q;
    m10_d      = count_en ? inc_m10 : m10_q;
    snap_s1_d  = snap_s1_q;
    snap_s10_d = snap_s10_q;
    snap_m1_d  = snap_m1_q;
    snap_m10_d = snap_m10_q;
    wrap_d     = count_en && at_max && !Clear;

    if (Clear) begin
      state_d    = IDLE;
      s1_d       = '0;
      s10_d      = '0;
      m1_d       = '0;
      m10_d      = '0;
      snap_s1_d  = '0;
      snap_s10_d = '0;
      snap_m1_d  = '0;
      snap_m10_d = '0;
    end else if (Start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSED;
        PAUSED:  state_d = RUN;
        LAP:     state_d = PAUSED;
        default: state_d = IDLE;
      endcase
    end else if (Lap) begin
      if (state_q == RUN) begin
        // snapshot takes the post-tick value so a same-cycle tick is included
        state_d    = LAP;
        snap_s1_d  = s1_d;
        snap_s10_d = s10_d;
        snap_m1_d  = m1_d;
        snap_m10_d = m10_d;
      end else if (state_q == LAP) begin
        state_d = RUN;
      end
    end
  end

  always_comb begin
    Lap_active = (state_q == LAP);
    Running    = (state_q == RUN) || (state_q == LAP);
    Wrap       = wrap_q;
    Sec_ones   = Lap_active ? snap_s1_q  : s1_q;
    Sec_tens   = Lap_active ? snap_s10_q : s10_q;
    Min_ones   = Lap_active ? snap_m1_q  : m1_q;
    Min_tens   = Lap_active ? snap_m10_q : m10_q;
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: one task per scenario, inline checks.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       ss = 1'b0;
  logic       lap = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, lap_active, wrap;
  logic [15:0] disp;
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  stopwatch_counter #(.MAX_MINUTES(59)) dut (
    .Clk_100mhz(clk),
    .Rst       (rst),
    .Tick      (tick),
    .Start_stop(ss),
    .Lap       (lap),
    .Clear     (clr),
    .Sec_ones  (sec_ones),
    .Sec_tens  (sec_tens),
    .Min_ones  (min_ones),
    .Min_tens  (min_tens),
    .Running   (running),
    .Lap_active(lap_active),
    .Wrap      (wrap)
  );

  always #5 clk = ~clk;

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle with the given inputs; outputs are settled on return.
  task automatic cyc(input logic t, input logic s, input logic l, input logic c);
    @(negedge clk);
    tick = t; ss = s; lap = l; clr = c;
    @(posedge clk);
    #1;
    tick = 1'b0; ss = 1'b0; lap = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (disp !== 16'h0000) $display("FAIL reset_digits: got %h want 0000", disp); else pass_cnt++;
    total_cnt++;
    if ({running, lap_active, wrap} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {running, lap_active, wrap}); else pass_cnt++;
  endtask

  task automatic test_count_75();
    logic wrap_seen;
    wrap_seen = 1'b0;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 75; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (wrap) wrap_seen = 1'b1;
    end
    total_cnt++;
    if (disp !== 16'h0115) $display("FAIL count75_digits: got %h want 0115", disp); else pass_cnt++;
    total_cnt++;
    if (running !== 1'b1) $display("FAIL count75_running: got %b want 1", running); else pass_cnt++;
    total_cnt++;
    if (wrap_seen !== 1'b0) $display("FAIL count75_wrap: got %b want 0", wrap_seen); else pass_cnt++;
  endtask

  task automatic test_minute_carry();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(59);
    total_cnt++;
    if (disp !== 16'h0059) $display("FAIL carry_pre: got %h want 0059", disp); else pass_cnt++;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== 16'h0100) $display("FAIL carry_post: got %h want 0100", disp); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic wrap_seen;
    wrap_seen = 1'b0;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 3599; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (wrap) wrap_seen = 1'b1;
    end
    total_cnt++;
    if (disp !== 16'h5959) $display("FAIL wrap_pre: got %h want 5959", disp); else pass_cnt++;
    total_cnt++;
    if (wrap_seen !== 1'b0) $display("FAIL wrap_early: got %b want 0", wrap_seen); else pass_cnt++;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== 16'h0000) $display("FAIL wrap_digits: got %h want 0000", disp); else pass_cnt++;
    total_cnt++;
    if ({wrap, running} !== 2'b11) $display("FAIL wrap_pulse: got %b want 11", {wrap, running}); else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({wrap, running} !== 2'b01) $display("FAIL wrap_clear: got %b want 01", {wrap, running}); else pass_cnt++;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== 16'h0001) $display("FAIL wrap_continue: got %h want 0001", disp); else pass_cnt++;
  endtask

  task automatic test_lap();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(5);
    total_cnt++;
    if (disp !== 16'h0010) $display("FAIL lap_frozen: got %h want 0010", disp); else pass_cnt++;
    total_cnt++;
    if ({lap_active, running} !== 2'b11)
      $display("FAIL lap_flags: got %b want 11", {lap_active, running}); else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (disp !== 16'h0015) $display("FAIL lap_release: got %h want 0015", disp); else pass_cnt++;
    total_cnt++;
    if (lap_active !== 1'b0) $display("FAIL lap_release_flag: got %b want 0", lap_active); else pass_cnt++;
    // Lap with a tick in the same cycle snapshots the ticked value
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    ticks(2);
    total_cnt++;
    if (disp !== 16'h0016) $display("FAIL lap_tick_snap: got %h want 0016", disp); else pass_cnt++;
    // Start_stop from LAP pauses and unfreezes
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({disp, running, lap_active} !== {16'h0018, 2'b00})
      $display("FAIL lap_to_pause: got %h/%b%b want 0018/00", disp, running, lap_active); else pass_cnt++;
    // Lap ignored while paused
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if ({running, lap_active} !== 2'b00)
      $display("FAIL lap_ignored_paused: got %b want 00", {running, lap_active}); else pass_cnt++;
  endtask

  task automatic test_pause();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(20);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({disp, running} !== {16'h0021, 1'b0})
      $display("FAIL pause_tick: got %h/%b want 0021/0", disp, running); else pass_cnt++;
    ticks(3);
    total_cnt++;
    if (disp !== 16'h0021) $display("FAIL pause_hold: got %h want 0021", disp); else pass_cnt++;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({disp, running} !== {16'h0021, 1'b1})
      $display("FAIL resume: got %h/%b want 0021/1", disp, running); else pass_cnt++;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== 16'h0022) $display("FAIL resume_count: got %h want 0022", disp); else pass_cnt++;
  endtask

  task automatic test_clear_and_rst();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(30);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if ({disp, running, wrap} !== {16'h0000, 2'b00})
      $display("FAIL clear_priority: got %h/%b%b want 0000/00", disp, running, wrap); else pass_cnt++;
    ticks(2);
    total_cnt++;
    if (disp !== 16'h0000) $display("FAIL idle_no_count: got %h want 0000", disp); else pass_cnt++;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if ({disp, lap_active} !== {16'h0005, 1'b1})
      $display("FAIL pre_rst_lap: got %h/%b want 0005/1", disp, lap_active); else pass_cnt++;
    do_reset();
    total_cnt++;
    if ({disp, running, lap_active, wrap} !== {16'h0000, 3'b000})
      $display("FAIL mid_rst: got %h/%b%b%b want 0000/000", disp, running, lap_active, wrap); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_count_75();
    test_minute_carry();
    test_wrap();
    test_lap();
    test_pause();
    test_clear_and_rst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
